// File: rtl/pe_os_acc_if.sv
// pe_os_acc_if: operand-stream, forwarding and drain-chain signals of one
// output-stationary processing element.
//   i_en, i_valid, i_last, i_mode, i_A, i_B : compute-side inputs
//   o_A, o_B, o_valid, o_last, o_mode        : registered east/south forward
//   i_shift, i_C, i_C_valid                  : drain chain from upstream
//   o_C, o_C_valid                           : result register
//   o_sat, o_err                             : sticky status flags
// modport slave is the PE itself; modport master is whatever drives it.
interface pe_os_acc_if #(
  parameter int W     = 16,
  parameter int ACC_W = 32
);
  logic             i_en;
  logic             i_valid;
  logic             i_last;
  logic             i_mode;
  logic [W-1:0]     i_A;
  logic [W-1:0]     i_B;
  logic [W-1:0]     o_A;
  logic [W-1:0]     o_B;
  logic             o_valid;
  logic             o_last;
  logic             o_mode;
  logic             i_shift;
  logic [ACC_W-1:0] i_C;
  logic             i_C_valid;
  logic [ACC_W-1:0] o_C;
  logic             o_C_valid;
  logic             o_sat;
  logic             o_err;

  modport slave (
    input  i_en, i_valid, i_last, i_mode, i_A, i_B,
    input  i_shift, i_C, i_C_valid,
    output o_A, o_B, o_valid, o_last, o_mode,
    output o_C, o_C_valid, o_sat, o_err
  );

  modport master (
    output i_en, i_valid, i_last, i_mode, i_A, i_B,
    output i_shift, i_C, i_C_valid,
    input  o_A, o_B, o_valid, o_last, o_mode,
    input  o_C, o_C_valid, o_sat, o_err
  );
endinterface

// File: rtl/pe_os_acc.sv
// pe_os_acc: output-stationary systolic PE. Multiplies streamed A/B pairs,
// accumulates into an ACC_W-bit accumulator (saturating when SAT=1, wrapping
// otherwise) until a pair marked last, then parks the tile result in a
// result register that drains along a column shift chain.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset, clears every register
//   bus   : pe_os_acc_if.slave (operand stream, forward, drain chain, flags)
// Parameters: W operand width, ACC_W accumulator width (>= 2*W),
//   SAT 1 = saturate on overflow, 0 = wrap.
module pe_os_acc #(
  parameter int W     = 16,
  parameter int ACC_W = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pe_os_acc_if.slave  bus
);

  localparam int PW = 2 * W;

  // Sign- or zero-extend both operands to PW bits, then multiply. The low PW
  // bits of that product are the exact signed or unsigned product.
  function automatic logic [PW-1:0] mul_ext(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic         mode);
    logic signed [PW-1:0] ea;
    logic signed [PW-1:0] eb;
    ea = {{W{mode & a[W-1]}}, a};
    eb = {{W{mode & b[W-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [ACC_W-1:0] prod_ext(input logic [PW-1:0] p,
                                                input logic          mode);
    logic signed [PW-1:0] ps;
    ps = p;
    if (mode) return ACC_W'(ps);
    else      return ACC_W'(p);
  endfunction

  // Clamp value for an overflowed add; neg selects the negative signed rail.
  function automatic logic [ACC_W-1:0] sat_clamp(input logic neg,
                                                 input logic mode);
    if (!mode)    return '1;
    else if (neg) return {1'b1, {(ACC_W-1){1'b0}}};
    else          return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  // Returns {overflow, result}. Signed overflow: like-signed inputs whose sum
  // sign differs; unsigned overflow: carry out of the ACC_W+1 bit sum.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                             input logic [ACC_W-1:0] p,
                                             input logic             mode);
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [ACC_W-1:0] res;
    sum = {1'b0, acc} + {1'b0, p};
    if (mode) ovf = (acc[ACC_W-1] == p[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    else      ovf = sum[ACC_W];
    res = sum[ACC_W-1:0];
    if (ovf && SAT) res = sat_clamp(acc[ACC_W-1], mode);
    return {ovf, res};
  endfunction

  logic [W-1:0]            a_p1;
  logic [W-1:0]            b_p1;
  logic                    vld_p1;
  logic                    last_p1;
  logic                    mode_p1;
  logic [PW-1:0]           prod_p2;
  logic                    vld_p2;
  logic                    last_p2;
  logic                    mode_p2;
  logic signed [ACC_W-1:0] acc_p3;
  logic [ACC_W-1:0]        c_q;
  logic                    c_vld_q;
  logic                    sat_q;
  logic                    err_q;

  logic [PW-1:0]    prod_nxt;
  logic [ACC_W-1:0] pext;
  logic [ACC_W:0]   add_r;
  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic             step3;
  logic             commit;

  assign prod_nxt = mul_ext(a_p1, b_p1, mode_p1);
  assign pext     = prod_ext(prod_p2, mode_p2);
  assign add_r    = acc_add(acc_p3, pext, mode_p2);
  assign sum      = add_r[ACC_W-1:0];
  assign ovf      = add_r[ACC_W];
  assign step3    = bus.i_en & vld_p2;
  assign commit   = step3 & last_p2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_p1    <= '0;
      b_p1    <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      mode_p1 <= 1'b0;
      prod_p2 <= '0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      mode_p2 <= 1'b0;
      acc_p3  <= '0;
    end else if (bus.i_en) begin
      // stage 1: operand capture, doubles as the forwarding register
      a_p1    <= bus.i_A;
      b_p1    <= bus.i_B;
      vld_p1  <= bus.i_valid;
      last_p1 <= bus.i_valid & bus.i_last;
      mode_p1 <= bus.i_mode;
      // stage 2: product
      prod_p2 <= prod_nxt;
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      mode_p2 <= mode_p1;
      // stage 3: accumulate; a last pair empties acc for the next tile
      if (vld_p2) acc_p3 <= last_p2 ? '0 : sum;
    end
  end

  // result register / drain chain, free-running with respect to i_en
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      c_q     <= '0;
      c_vld_q <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (step3 && ovf) sat_q <= 1'b1;
      if (bus.i_shift) begin
        c_q     <= bus.i_C;
        c_vld_q <= bus.i_C_valid;
        if (commit) err_q <= 1'b1;
      end else if (commit) begin
        if (!c_vld_q) begin
          c_q     <= sum;
          c_vld_q <= 1'b1;
        end else begin
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.o_A       = a_p1;
  assign bus.o_B       = b_p1;
  assign bus.o_valid   = vld_p1;
  assign bus.o_last    = last_p1;
  assign bus.o_mode    = mode_p1;
  assign bus.o_C       = c_q;
  assign bus.o_C_valid = c_vld_q;
  assign bus.o_sat     = sat_q;
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_pe_os_acc.sv
// tb_pe_os_acc: directed-vector bench for pe_os_acc. Two instances share the
// same stimulus: one saturating (SAT=1), one wrapping (SAT=0).
module tb_pe_os_acc;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_tests = 0;
  int   n_failed = 0;

  always #5 i_clk = ~i_clk;

  pe_os_acc_if #(.W(16), .ACC_W(32)) bus_s ();
  pe_os_acc_if #(.W(16), .ACC_W(32)) bus_w ();

  pe_os_acc #(.W(16), .ACC_W(32), .SAT(1'b1)) dut_sat (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus_s)
  );

  pe_os_acc #(.W(16), .ACC_W(32), .SAT(1'b0)) dut_wrap (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus_w)
  );

  assign bus_w.i_en      = bus_s.i_en;
  assign bus_w.i_valid   = bus_s.i_valid;
  assign bus_w.i_last    = bus_s.i_last;
  assign bus_w.i_mode    = bus_s.i_mode;
  assign bus_w.i_A       = bus_s.i_A;
  assign bus_w.i_B       = bus_s.i_B;
  assign bus_w.i_shift   = bus_s.i_shift;
  assign bus_w.i_C       = bus_s.i_C;
  assign bus_w.i_C_valid = bus_s.i_C_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pair(input logic [15:0] a, input logic [15:0] b, input logic last);
    bus_s.i_valid = 1'b1;
    bus_s.i_A     = a;
    bus_s.i_B     = b;
    bus_s.i_last  = last;
    tick();
  endtask

  task automatic idle(input int n);
    bus_s.i_valid = 1'b0;
    bus_s.i_last  = 1'b0;
    tick(n);
  endtask

  task automatic drain();
    bus_s.i_shift   = 1'b1;
    bus_s.i_C       = '0;
    bus_s.i_C_valid = 1'b0;
    tick();
    bus_s.i_shift   = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst           = 1'b1;
    bus_s.i_en      = 1'b1;
    bus_s.i_valid   = 1'b0;
    bus_s.i_last    = 1'b0;
    bus_s.i_mode    = 1'b0;
    bus_s.i_A       = '0;
    bus_s.i_B       = '0;
    bus_s.i_shift   = 1'b0;
    bus_s.i_C       = '0;
    bus_s.i_C_valid = 1'b0;
    tick(2);
    i_rst = 1'b0;

    check("rst_oC",      bus_s.o_C,       64'h0);
    check("rst_oCvalid", bus_s.o_C_valid, 64'h0);
    check("rst_osat",    bus_s.o_sat,     64'h0);
    check("rst_oerr",    bus_s.o_err,     64'h0);
    check("rst_oA",      bus_s.o_A,       64'h0);
    check("rst_ovalid",  bus_s.o_valid,   64'h0);

    // signed tile 3*4 + -2*5 + 7*-1 = -5
    bus_s.i_mode = 1'b1;
    pair(16'd3, 16'd4, 1'b0);
    check("fwd_oA",     bus_s.o_A,     64'd3);
    check("fwd_oB",     bus_s.o_B,     64'd4);
    check("fwd_ovalid", bus_s.o_valid, 64'h1);
    check("fwd_omode",  bus_s.o_mode,  64'h1);
    pair(16'hFFFE, 16'd5, 1'b0);
    pair(16'd7, 16'hFFFF, 1'b1);
    check("fwd_olast",  bus_s.o_last,  64'h1);
    idle(1);
    check("sgn_early_vld", bus_s.o_C_valid, 64'h0);
    tick();
    check("sgn_vld",  bus_s.o_C_valid, 64'h1);
    check("sgn_oC",   bus_s.o_C,       64'hFFFFFFFB);
    check("sgn_sat",  bus_s.o_sat,     64'h0);
    check("sgn_oC_w", bus_w.o_C,       64'hFFFFFFFB);
    drain();
    check("drain_vld", bus_s.o_C_valid, 64'h0);

    // unsigned overflow: 2 * 0xFFFE0001 = 0x1FFFC0002
    bus_s.i_mode = 1'b0;
    pair(16'hFFFF, 16'hFFFF, 1'b0);
    pair(16'hFFFF, 16'hFFFF, 1'b1);
    idle(2);
    check("usat_oC",    bus_s.o_C,   64'hFFFFFFFF);
    check("usat_sat",   bus_s.o_sat, 64'h1);
    check("uwrap_oC",   bus_w.o_C,   64'hFFFC0002);
    check("uwrap_sat",  bus_w.o_sat, 64'h1);

    // signed overflow: 2 * 0x40000000 = 0x80000000
    do_reset();
    check("rst2_sat", bus_s.o_sat, 64'h0);
    bus_s.i_mode = 1'b1;
    pair(16'h8000, 16'h8000, 1'b0);
    pair(16'h8000, 16'h8000, 1'b1);
    idle(2);
    check("ssat_oC",   bus_s.o_C,   64'h7FFFFFFF);
    check("ssat_sat",  bus_s.o_sat, 64'h1);
    check("swrap_oC",  bus_w.o_C,   64'h80000000);
    drain();

    // stall between pairs: 2*3 + 4*5 = 26
    bus_s.i_mode = 1'b0;
    pair(16'd2, 16'd3, 1'b0);
    bus_s.i_en    = 1'b0;
    bus_s.i_valid = 1'b1;
    bus_s.i_A     = 16'd9;
    bus_s.i_B     = 16'd9;
    tick();
    check("stall_oA1", bus_s.o_A, 64'd2);
    tick();
    check("stall_oB2", bus_s.o_B, 64'd3);
    check("stall_noC", bus_s.o_C_valid, 64'h0);
    bus_s.i_en = 1'b1;
    pair(16'd4, 16'd5, 1'b1);
    check("stall_oA_resume", bus_s.o_A, 64'd4);
    idle(2);
    check("stall_vld", bus_s.o_C_valid, 64'h1);
    check("stall_oC",  bus_s.o_C,       64'd26);
    drain();

    // back-to-back tiles 10 then 20; second commit collides
    pair(16'd2, 16'd5, 1'b1);
    pair(16'd4, 16'd5, 1'b1);
    idle(2);
    check("coll_oC",  bus_s.o_C,       64'd10);
    check("coll_vld", bus_s.o_C_valid, 64'h1);
    check("coll_err", bus_s.o_err,     64'h1);
    bus_s.i_shift   = 1'b1;
    bus_s.i_C       = 32'h55;
    bus_s.i_C_valid = 1'b1;
    tick();
    bus_s.i_shift   = 1'b0;
    bus_s.i_C_valid = 1'b0;
    check("shift_oC",  bus_s.o_C,       64'h55);
    check("shift_vld", bus_s.o_C_valid, 64'h1);

    // reset mid-tile, with a shift request that reset must override
    pair(16'd5, 16'd5, 1'b0);
    pair(16'd6, 16'd6, 1'b0);
    idle(1);
    i_rst           = 1'b1;
    bus_s.i_shift   = 1'b1;
    bus_s.i_C       = 32'h77;
    bus_s.i_C_valid = 1'b1;
    tick();
    i_rst           = 1'b0;
    bus_s.i_shift   = 1'b0;
    bus_s.i_C_valid = 1'b0;
    check("mrst_oC",  bus_s.o_C,       64'h0);
    check("mrst_vld", bus_s.o_C_valid, 64'h0);
    check("mrst_err", bus_s.o_err,     64'h0);
    check("mrst_sat", bus_s.o_sat,     64'h0);
    pair(16'd1, 16'd1, 1'b1);
    idle(2);
    check("post_oC",  bus_s.o_C,       64'd1);
    check("post_vld", bus_s.o_C_valid, 64'h1);
    check("post_sat", bus_s.o_sat,     64'h0);
    check("post_err", bus_s.o_err,     64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/pe_os_acc.md
# pe_os_acc

Parametrised output-stationary processing element for the systolic array, successor to the fixed 16-bit PE. Multiplies streamed A/B operands, accumulates into a wide saturating accumulator over a tile delimited by a `last` marker, and forwards operands to east/south neighbours through registered pass-through. Completed tile results are parked in a result register and drained along a column shift chain independent of the compute pipeline.

## Interface
- `W`, 16: operand width.
- `ACC_W`, 32: accumulator/result width; must be ≥ 2*W.
- `SAT`, 1: 1 = saturate accumulator on overflow, 0 = wrap modulo 2^ACC_W.

- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_en`  in  1  compute-pipeline enable; 0 stalls stages 1-3 and forwarding regs.
- `i_valid`  in  1  i_A/i_B carry a valid operand pair.
- `i_last`  in  1  qualifies the final pair of a tile (ignored unless i_valid).
- `i_mode`  in  1  0 = unsigned operands, 1 = two's-complement signed.
- `i_A`, `i_B`  in  W  operands.
- `o_A`, `o_B`  out  W  registered operand forward.
- `o_valid`, `o_last`, `o_mode`  out  1  registered forward of i_valid/i_last/i_mode.
- `i_shift`  in  1  drain-chain shift strobe (not gated by i_en).
- `i_C`  in  ACC_W  upstream result on drain chain.
- `i_C_valid`  in  1  upstream result valid.
- `o_C`  out  ACC_W  result register.
- `o_C_valid`  out  1  result register occupied.
- `o_sat`  out  1  sticky: any saturation/wrap event since reset.
- `o_err`  out  1  sticky: a tile result was dropped.

## Operation
- Stage 1 (when i_en): capture i_A, i_B, i_valid, i_last, i_mode; these registers drive o_A/o_B/o_valid/o_last/o_mode directly.
- Stage 2 (when i_en): product = s1_A*s1_B, 2*W bits, signed or unsigned per s1_mode; valid/last/mode pipelined alongside.
- Stage 3 (when i_en and s2_valid): sum = acc + product, product sign/zero-extended to ACC_W per mode, computed at ACC_W+1 bits.
  - Overflow: signed mode when sum sign differs from both like-signed inputs; unsigned mode on carry out. SAT=1 clamps to 2^(ACC_W-1)-1 / -2^(ACC_W-1) (signed) or 2^ACC_W-1 (unsigned); SAT=0 wraps. Either way sets o_sat.
  - s2_last=0: acc <= sum. s2_last=1: commit sum to result register, acc <= 0.
- Mode is per operand pair; mixing modes within a tile is undefined.
- Result register (drain chain), evaluated every cycle regardless of i_en:
  - i_shift=1: o_C <= i_C, o_C_valid <= i_C_valid. A commit in the same cycle is dropped, o_err <= 1.
  - i_shift=0, commit, o_C_valid=0: o_C <= sum, o_C_valid <= 1.
  - i_shift=0, commit, o_C_valid=1: commit dropped, o_err <= 1, o_C unchanged.
  - Otherwise hold.
- i_en=0: stages 1-3 and acc hold; outputs o_A/o_B/o_valid/o_last/o_mode hold last value.

## Timing
- Reset (i_rst=1 at edge): every register including acc, s1/s2 and all outputs (o_A, o_B, o_valid, o_last, o_mode, o_C, o_C_valid, o_sat, o_err) to 0. Reset overrides i_en and i_shift; in-flight tile discarded.
- Forward latency: i_* to o_* = 1 enabled edge.
- Compute latency: pair presented before edge N (i_en high on N, N+1, N+2) reaches acc at edge N+2; a last pair appears on o_C with o_C_valid=1 after edge N+2.
- Stall cycles insert directly into the above; no data lost or duplicated across stalls.
- Back-to-back tiles: a new tile's first pair may follow the prior last pair on the next cycle; acc clears on commit so no bubble required.
- Throughput: one pair per enabled cycle.

## Test plan
- Signed tile, mode=1: pairs (3,4),(-2,5),(7,-1) last on third, consecutive -> o_C=0xFFFFFFFB (-5), o_C_valid rises 3 edges after third pair, o_sat=0.
- Unsigned saturation, mode=0, SAT=1: (0xFFFF,0xFFFF) twice, last on second -> o_C=0xFFFFFFFF, o_sat=1; repeat with SAT=0 -> o_C=0xFFFC0002.
- Signed saturation, mode=1: (0x8000,0x8000) twice, last -> o_C=0x7FFFFFFF, o_sat=1.
- Stall: tile (2,3),(4,5) with i_en low 2 cycles between pairs -> o_C=26, o_A/o_B frozen during stall, no extra accumulation.
- Drain/collision: commit 10, leave o_C_valid=1, commit second tile 20 -> o_C=10, o_err=1; then i_shift with i_C=0x55,i_C_valid=1 -> o_C=0x55.
- Reset mid-tile: two pairs accumulated, i_rst pulse, then tile (1,1) last -> o_C=1, all flags 0.
